// File: rtl/interp_scheduler_pkg.sv
// Shared widths, defaults and FSM encoding for the
// stereo interpolation scheduler.
package interp_scheduler_pkg;

  localparam int DATA_W = 24;
  localparam int COEF_W = 11;
  localparam int PROD_W = 35;
  localparam int ACC_W = 36;
  localparam int SAMPLE_DIV_DEF = 512;

  localparam logic [COEF_W-1:0] PHASE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT
  } state_t;

  function automatic logic [ACC_W-1:0] sext(
    input logic [PROD_W-1:0] p
  );
    return {p[PROD_W-1], p};
  endfunction

endpackage

// File: rtl/interp_tick_gen.sv
// Output-sample tick: one strobe every SAMPLE_DIV clocks
// while run is high.
module interp_tick_gen #(
  parameter int SAMPLE_DIV = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/interp_scheduler.sv
// Linear interpolation scheduler: captures L/R samples, and on
// each tick runs four ops through a shared external multiplier.
module interp_scheduler
  import interp_scheduler_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int MULT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              din_en,
  input  logic [DATA_W-1:0] l_data_in,
  input  logic [DATA_W-1:0] r_data_in,
  output logic              mult_en,
  output logic [DATA_W-1:0] mult_a,
  output logic [COEF_W-1:0] mult_b,
  input  logic [PROD_W-1:0] mult_p,
  output logic              dout_valid,
  output logic [ACC_W-1:0]  l_data_out,
  output logic [ACC_W-1:0]  r_data_out,
  output logic              primed,
  output logic              busy
);

  localparam logic [1:0] DRAIN_LAST = 2'(MULT_LAT - 1);

  logic              tick;
  logic [COEF_W-1:0] phase;
  logic [COEF_W-1:0] period;
  logic [COEF_W-1:0] ph;
  logic [1:0]        strobes;
  logic [DATA_W-1:0] l_s0, l_s1, r_s0, r_s1;
  logic [DATA_W-1:0] sl0, sl1, sr0, sr1;
  logic [COEF_W-1:0] c0, c1;
  state_t            state;
  logic [1:0]        cnt;
  logic              start;
  logic              fin;
  logic [MULT_LAT-1:0] tag_vld;
  logic [MULT_LAT-1:0] tag_ch;
  logic [ACC_W-1:0]  acc_l, acc_r;
  logic [ACC_W-1:0]  acc_l_nx, acc_r_nx;

  interp_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  assign ph = (phase > period) ? period : phase;
  assign primed = (strobes == 2'd2);
  assign busy = (state != S_IDLE);
  assign dout_valid = (state == S_OUT);
  assign start = (state == S_IDLE) && tick && primed;
  assign fin = run && (state == S_DRAIN) && (cnt == DRAIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      period <= '0;
      l_s0 <= '0;
      l_s1 <= '0;
      r_s0 <= '0;
      r_s1 <= '0;
    end else if (din_en) begin
      phase <= '0;
      period <= phase;
      l_s1 <= l_s0;
      l_s0 <= l_data_in;
      r_s1 <= r_s0;
      r_s0 <= r_data_in;
    end else if (phase != PHASE_MAX) begin
      phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobes <= '0;
    end else if (!run) begin
      strobes <= '0;
    end else if (din_en && !primed) begin
      strobes <= strobes + 2'd1;
    end
  end

  // Snapshot isolates the sequence from captures arriving mid-flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sl0 <= '0;
      sl1 <= '0;
      sr0 <= '0;
      sr1 <= '0;
      c0 <= '0;
      c1 <= '0;
    end else if (start) begin
      sl0 <= l_s0;
      sl1 <= l_s1;
      sr0 <= r_s0;
      sr1 <= r_s1;
      c0 <= ph;
      c1 <= period - ph;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
    end else if (!run) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) state <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= S_DRAIN;
        end
        S_DRAIN: begin
          cnt <= cnt + 2'd1;
          if (cnt == DRAIN_LAST) begin
            state <= S_OUT;
            cnt <= '0;
          end
        end
        S_OUT: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mult_en = 1'b0;
    mult_a = '0;
    mult_b = '0;
    if (run && state == S_ISSUE) begin
      mult_en = 1'b1;
      unique case (cnt)
        2'd0: begin mult_a = sl1; mult_b = c1; end
        2'd1: begin mult_a = sl0; mult_b = c0; end
        2'd2: begin mult_a = sr1; mult_b = c1; end
        2'd3: begin mult_a = sr0; mult_b = c0; end
      endcase
    end
  end

  // Tags travel alongside the multiplier so each product lands
  // in the right channel; ops 2 and 3 are the right channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld <= '0;
      tag_ch <= '0;
    end else if (!run) begin
      tag_vld <= '0;
      tag_ch <= '0;
    end else begin
      tag_vld[0] <= mult_en;
      tag_ch[0] <= cnt[1];
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
    end
  end

  always_comb begin
    acc_l_nx = acc_l;
    acc_r_nx = acc_r;
    if (start) begin
      acc_l_nx = '0;
      acc_r_nx = '0;
    end else if (tag_vld[MULT_LAT-1]) begin
      if (tag_ch[MULT_LAT-1]) acc_r_nx = acc_r + sext(mult_p);
      else acc_l_nx = acc_l + sext(mult_p);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_l <= '0;
      acc_r <= '0;
      l_data_out <= '0;
      r_data_out <= '0;
    end else begin
      acc_l <= acc_l_nx;
      acc_r <= acc_r_nx;
      if (fin) begin
        l_data_out <= acc_l_nx;
        r_data_out <= acc_r_nx;
      end
    end
  end

endmodule

// File: tb/tb_interp_scheduler.sv
// Directed bench for interp_scheduler with a cycle-level
// reference model and a latency-accurate multiplier model.
module tb_interp_scheduler;

  localparam int DIV = 512;
  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        run;
  logic        din_en;
  logic [23:0] l_data_in;
  logic [23:0] r_data_in;
  logic        mult_en;
  logic [23:0] mult_a;
  logic [10:0] mult_b;
  logic [34:0] mult_p;
  logic        dout_valid;
  logic [35:0] l_data_out;
  logic [35:0] r_data_out;
  logic        primed;
  logic        busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  interp_scheduler #(
    .SAMPLE_DIV(DIV),
    .MULT_LAT  (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .din_en    (din_en),
    .l_data_in (l_data_in),
    .r_data_in (r_data_in),
    .mult_en   (mult_en),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .dout_valid(dout_valid),
    .l_data_out(l_data_out),
    .r_data_out(r_data_out),
    .primed    (primed),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: LAT-deep signed pipeline.
  logic signed [34:0] prod;
  logic signed [34:0] pipe [LAT];
  assign prod = $signed(mult_a) * $signed({1'b0, mult_b});
  assign mult_p = pipe[LAT-1];
  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic chk(string nm, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d",
               nm, cyc, act, exp);
    end
  endtask

  // Reference model, evaluated once per cycle on the falling edge.
  longint m_l0, m_l1, m_r0, m_r1;
  int     m_phase, m_period, m_strobes, m_tcnt;
  bit     m_pend;
  int     m_t0;
  longint op_a [4];
  int     op_b [4];
  longint ex_l, ex_r, last_l, last_r;

  initial begin
    bit     e_busy, e_en, e_dv, tk;
    longint e_a;
    int     e_b, ph, k;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_l0 = 0; m_l1 = 0; m_r0 = 0; m_r1 = 0;
        m_phase = 0; m_period = 0; m_strobes = 0; m_tcnt = 0;
        m_pend = 0; m_t0 = 0; last_l = 0; last_r = 0;
      end
      e_busy = m_pend && cyc >= m_t0 + 1 && cyc <= m_t0 + 5 + LAT;
      e_en = m_pend && run && cyc >= m_t0 + 1 && cyc <= m_t0 + 4;
      e_dv = m_pend && cyc == m_t0 + 5 + LAT;
      e_a = 0;
      e_b = 0;
      if (e_en) begin
        k = cyc - m_t0 - 1;
        e_a = op_a[k];
        e_b = op_b[k];
      end
      if (e_dv) begin
        last_l = ex_l;
        last_r = ex_r;
      end
      chk("mult_en", longint'(mult_en), longint'(e_en));
      chk("mult_a", longint'($signed(mult_a)), e_a);
      chk("mult_b", longint'(mult_b), longint'(e_b));
      chk("dout_valid", longint'(dout_valid), longint'(e_dv));
      chk("l_data_out", longint'($signed(l_data_out)), last_l);
      chk("r_data_out", longint'($signed(r_data_out)), last_r);
      chk("primed", longint'(primed), longint'(m_strobes >= 2));
      chk("busy", longint'(busy), longint'(e_busy));
      if (!reset) begin
        tk = run && m_tcnt == DIV - 1;
        if (tk && m_strobes >= 2 && !e_busy) begin
          ph = (m_phase < m_period) ? m_phase : m_period;
          m_pend = 1;
          m_t0 = cyc;
          op_a = '{m_l1, m_l0, m_r1, m_r0};
          op_b = '{m_period - ph, ph, m_period - ph, ph};
          ex_l = m_l1 * (m_period - ph) + m_l0 * ph;
          ex_r = m_r1 * (m_period - ph) + m_r0 * ph;
        end
        if (!run) m_pend = 0;
        m_tcnt = (run && !tk) ? m_tcnt + 1 : 0;
        if (din_en) begin
          m_l1 = m_l0;
          m_r1 = m_r0;
          m_l0 = longint'($signed(l_data_in));
          m_r0 = longint'($signed(r_data_in));
          m_period = m_phase;
          m_phase = 0;
        end else if (m_phase < 2047) begin
          m_phase++;
        end
        if (!run) m_strobes = 0;
        else if (din_en && m_strobes < 2) m_strobes++;
      end
    end
  end

  task automatic at(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(int c, int l, int r);
    at(c);
    din_en = 1'b1;
    l_data_in = l[23:0];
    r_data_in = r[23:0];
    at(c + 1);
    din_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    din_en = 1'b0;
    l_data_in = '0;
    r_data_in = '0;
    at(2);
    chk("rst_dout_valid", longint'(dout_valid), 0);
    chk("rst_l_out", longint'(l_data_out), 0);
    chk("rst_primed", longint'(primed), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_mult_en", longint'(mult_en), 0);
    at(5);
    reset = 1'b0;
    at(10);
    run = 1'b1;
    // Tick 521: per 256, ph 64.
    pulse(199, 1000, -4096);
    pulse(456, 2000, 4096);
    at(528);
    chk("lit_dv_528", longint'(dout_valid), 1);
    chk("lit_l_320000", longint'($signed(l_data_out)), 320000);
    // Tick 1033: R s1 -4096 s0 4096, per 256, ph 128.
    pulse(647, 5, -4096);
    pulse(904, -7, 4096);
    at(1040);
    chk("lit_dv_1040", longint'(dout_valid), 1);
    chk("lit_r_zero", longint'($signed(r_data_out)), 0);
    // Tick 2057: phase 300 clamps to per 256.
    pulse(1499, 111, 7);
    pulse(1756, -3, 9);
    at(2064);
    chk("lit_l_clamp", longint'($signed(l_data_out)), -768);
    // Tick 4617: phase saturates, per 2047, ph 0.
    pulse(2115, 3, -8388608);
    pulse(4616, 2, -8388608);
    at(4624);
    chk("lit_r_fullscale", longint'($signed(r_data_out)),
        -64'sd17171480576);
    // Tick 5129 with coincident strobe: old samples and phase.
    pulse(5129, 999, 5);
    at(5136);
    chk("lit_l_coincident", longint'($signed(l_data_out)), 5629);
    // Re-arm with a single strobe: three silent ticks.
    at(5200);
    run = 1'b0;
    at(5210);
    run = 1'b1;
    pulse(5300, 10, 20);
    at(5721);
    chk("lit_unprimed_1", longint'(primed), 0);
    at(5722);
    chk("lit_unprimed_busy", longint'(busy), 0);
    at(6233);
    chk("lit_unprimed_2", longint'(primed), 0);
    at(6745);
    chk("lit_unprimed_3", longint'(primed), 0);
    pulse(6800, 30, -40);
    at(7264);
    chk("lit_dv_reprimed", longint'(dout_valid), 1);
    // Tick 7769: drop run two cycles into the issue phase.
    at(7772);
    run = 1'b0;
    at(7773);
    chk("lit_abort_busy", longint'(busy), 0);
    at(7777);
    run = 1'b1;
    pulse(7900, 123, -321);
    pulse(8100, -456, 654);
    at(8295);
    chk("lit_dv_8295", longint'(dout_valid), 1);
    // Tick 8800: reset while draining.
    at(8805);
    reset = 1'b1;
    #1;
    chk("lit_rst_dv", longint'(dout_valid), 0);
    chk("lit_rst_l", longint'(l_data_out), 0);
    chk("lit_rst_r", longint'(r_data_out), 0);
    chk("lit_rst_en", longint'(mult_en), 0);
    chk("lit_rst_busy", longint'(busy), 0);
    at(8810);
    reset = 1'b0;
    pulse(9000, 77, 88);
    pulse(9200, -99, 11);
    at(9328);
    chk("lit_dv_after_reset", longint'(dout_valid), 1);
    at(9340);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interp_scheduler.md
INTERP_SCHEDULER -- requirements
Module: interp_scheduler

Interface
REQ-001 Parameter SAMPLE_DIV, default 512: clocks per output sample (96 kHz from 49.152 MHz); legal range 16..2048.
REQ-002 Parameter MULT_LAT, default 2: cycles from a mult_en issue to the matching mult_p being valid; legal range 1..3.
REQ-003 clk  in  1  system clock (mclk 49.152 MHz); the block has one clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 run  in  1  enable; low forces idle.
REQ-006 din_en  in  1  one-cycle input-sample strobe, shared by L and R.
REQ-007 l_data_in  in  24  signed left sample, valid with din_en.
REQ-008 r_data_in  in  24  signed right sample, valid with din_en.
REQ-009 mult_en  out  1  issue strobe to the shared external multiplier.
REQ-010 mult_a  out  24  signed multiplicand.
REQ-011 mult_b  out  11  unsigned coefficient.
REQ-012 mult_p  in  35  signed product, returned MULT_LAT cycles after issue.
REQ-013 dout_valid  out  1  one-cycle output strobe.
REQ-014 l_data_out  out  36  signed interpolated left value.
REQ-015 r_data_out  out  36  signed interpolated right value.
REQ-016 primed  out  1  high once two din_en strobes have been seen since run rose.
REQ-017 busy  out  1  high while a sequence is in progress.

Function
REQ-018 Tick counter: counts 0..SAMPLE_DIV-1 while run is high; tick = 1 for one cycle when the count equals SAMPLE_DIV-1; cleared while run is low.
REQ-019 Phase counter: increments every cycle and saturates at 2047; on din_en it loads 0, period <= phase counter, s1 <= s0, s0 <= data_in (L and R).
REQ-020 Snapshot: at the edge where FSM is IDLE and tick = 1, latch s0/s1 (L and R), per = period, ph = min(phase counter, per); c0 = ph, c1 = per - ph.
REQ-021 FSM states: IDLE -> ISSUE (4 cycles, op index 0..3) -> DRAIN (MULT_LAT cycles) -> OUT (1 cycle) -> IDLE.
REQ-022 ISSUE order, one op per cycle with mult_en = 1: (L.s1, c1), (L.s0, c0), (R.s1, c1), (R.s0, c0).
REQ-023 Products are accumulated by sign-extending to 36 bits, in the cycle each arrives (issue + MULT_LAT); no truncation.
REQ-024 Result: out = s1*c1 + s0*c0; s0 is the newest sample.
REQ-025 OUT: l_data_out/r_data_out are registered and dout_valid = 1 for one cycle, exactly 5+MULT_LAT cycles after the tick cycle (7 with the default); outputs hold until the next OUT.
REQ-026 A tick while primed = 0: snapshot and sequence are skipped, with no mult_en and no dout_valid.
REQ-027 A tick while busy cannot occur (SAMPLE_DIV >= 16 > sequence length); the FSM ignores ticks outside IDLE.
REQ-028 A din_en during a sequence updates only the capture registers, never the snapshot in flight.
REQ-029 A din_en in the same cycle as a tick: the snapshot takes the pre-update values.
REQ-030 run falling mid-sequence: the FSM returns to IDLE next cycle with no dout_valid; primed clears; outputs hold; mult_p arriving afterwards is ignored.
REQ-031 mult_a/mult_b are 0 whenever mult_en = 0.

Reset
REQ-032 Reset asserted: all counters 0, FSM IDLE, capture/snapshot/accumulator registers 0, mult_en 0, mult_a 0, mult_b 0, dout_valid 0, l/r_data_out 0, primed 0, busy 0.
REQ-033 Reset release: the block stays idle until run is high; no output before the first tick after two strobes.

Structure
REQ-034 Shared package holds the FSM state enum, the width constants (DATA_W 24, COEF_W 11, PROD_W 35, ACC_W 36) and the default SAMPLE_DIV.
REQ-035 One sub-module, interp_tick_gen, implements the tick counter; all other logic is local. The multiplier stays external so it can be shared.

Verification
REQ-036 Bench models the multiplier as a MULT_LAT-deep signed pipeline.
REQ-037 din_en every 256 clk, L s1 = 1000 / s0 = 2000, phase 64 at tick -> l_data_out = 320000, dout_valid 7 clk after the tick.
REQ-038 R s1 = -4096, s0 = 4096, per 256, ph 128 -> r_data_out = 0; R s1 = -8388608, s0 = -8388608, per 2047, ph 0 -> r_data_out = -17171480576.
REQ-039 Strobes stop after per = 256 so the phase counter reaches 300 -> clamp gives ph = 256, out = s0*256; counter saturates at 2047 with no wrap.
REQ-040 Only one din_en after run rises -> primed = 0, no mult_en, no dout_valid across 3 ticks; second strobe -> the next tick produces output.
REQ-041 run dropped 2 clk into ISSUE, and separately reset asserted in DRAIN -> no dout_valid; reset case shows all outputs 0 asynchronously; normal output resumes after re-prime.
REQ-042 din_en coincident with a tick -> result uses the old s0/s1 and the old phase.
